// File: rtl/lap_controller.sv
// Stopwatch front-panel controller: debounces three buttons, sequences the stopwatch
// through clear/idle/run/pause and records lap times into a small buffer.
module lap_controller #(
  parameter int SECONDS_WIDTH   = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LAP_DEPTH       = 4
) (
  input  logic                       i_clk,
  input  logic                       i_sync_reset,
  input  logic                       i_btn_start_stop,
  input  logic                       i_btn_lap,
  input  logic                       i_btn_clear,
  input  logic [SECONDS_WIDTH-1:0]   i_seconds_in,
  output logic                       o_start,
  output logic                       o_continue_pause,
  output logic                       o_sw_reset_n,
  output logic                       o_running,
  input  logic [$clog2(LAP_DEPTH)-1:0] i_lap_sel,
  output logic [SECONDS_WIDTH-1:0]   o_lap_value,
  output logic [$clog2(LAP_DEPTH):0] o_lap_count,
  output logic                       o_lap_full
);

  localparam int SEL_W = $clog2(LAP_DEPTH);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W:0] LAP_FULL_CNT = (SEL_W + 1)'(LAP_DEPTH);

  typedef enum logic [1:0] {StClearing, StIdle, StRunning, StPaused} state_t;

  // Button bit order: [0] start_stop, [1] lap, [2] clear
  logic [2:0]       w_btn;
  logic [2:0]       r_sync1, r_sync2, r_level, r_level_q, r_press;
  logic [CNT_W-1:0] r_cnt [3];

  logic                     w_ss_evt, w_lap_evt, w_clr_evt;
  state_t                   r_state;
  logic                     r_clr_cnt;
  logic                     r_start, r_continue_pause, r_sw_reset_n, r_running;
  logic [SEL_W:0]           r_lap_count;
  logic                     r_lap_full;
  logic [SECONDS_WIDTH-1:0] r_lap [LAP_DEPTH];

  assign w_btn = {i_btn_clear, i_btn_lap, i_btn_start_stop};

  // Counter runs only while the synchronized input disagrees with the debounced
  // level; any return to agreement (i.e. a bounce) restarts it.
  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_level_q <= '0;
      r_press   <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_ss_evt  = r_press[0];
  assign w_lap_evt = r_press[1];
  assign w_clr_evt = r_press[2];

  always_ff @(posedge i_clk) begin
    if (i_sync_reset) begin
      r_state          <= StClearing;
      r_clr_cnt        <= 1'b0;
      r_start          <= 1'b0;
      r_continue_pause <= 1'b0;
      r_sw_reset_n     <= 1'b0;
      r_running        <= 1'b0;
      r_lap_count      <= '0;
      r_lap_full       <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) r_lap[i] <= '0;
    end else begin
      r_start          <= 1'b0;
      r_continue_pause <= 1'b0;
      unique case (r_state)
        StClearing: begin
          if (r_clr_cnt) begin
            r_state      <= StIdle;
            r_sw_reset_n <= 1'b1;
          end
          r_clr_cnt <= 1'b1;
        end
        StIdle: begin
          if (w_clr_evt) begin
            r_state      <= StClearing;
            r_clr_cnt    <= 1'b0;
            r_sw_reset_n <= 1'b0;
            r_lap_count  <= '0;
            r_lap_full   <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_lap[i] <= '0;
          end else if (w_ss_evt) begin
            r_state   <= StRunning;
            r_start   <= 1'b1;
            r_running <= 1'b1;
          end
        end
        StRunning: begin
          if (w_ss_evt) begin
            r_state          <= StPaused;
            r_continue_pause <= 1'b1;
            r_running        <= 1'b0;
          end
          if (w_lap_evt) begin
            if (r_lap_count == LAP_FULL_CNT) begin
              r_lap_full <= 1'b1;
            end else begin
              r_lap[r_lap_count[SEL_W-1:0]] <= i_seconds_in;
              r_lap_count <= r_lap_count + 1'b1;
            end
          end
        end
        StPaused: begin
          // Clear takes priority over a simultaneous start_stop
          if (w_clr_evt) begin
            r_state      <= StClearing;
            r_clr_cnt    <= 1'b0;
            r_sw_reset_n <= 1'b0;
            r_lap_count  <= '0;
            r_lap_full   <= 1'b0;
            for (int i = 0; i < LAP_DEPTH; i++) r_lap[i] <= '0;
          end else if (w_ss_evt) begin
            r_state          <= StRunning;
            r_continue_pause <= 1'b1;
            r_running        <= 1'b1;
          end
        end
        default: r_state <= StClearing;
      endcase
    end
  end

  always_comb begin
    o_lap_value = '0;
    if ({1'b0, i_lap_sel} < r_lap_count) o_lap_value = r_lap[i_lap_sel];
  end

  assign o_start          = r_start;
  assign o_continue_pause = r_continue_pause;
  assign o_sw_reset_n     = r_sw_reset_n;
  assign o_running        = r_running;
  assign o_lap_count      = r_lap_count;
  assign o_lap_full       = r_lap_full;

endmodule

// File: doc/lap_controller.md
LAP_CONTROLLER -- requirements
Module: lap_controller

Interface
REQ-001 SHALL have parameter SECONDS_WIDTH, default 8, width of seconds value and lap entries.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, cycles a synchronized button must be stable before its debounced level changes.
REQ-003 SHALL have parameter LAP_DEPTH, default 4, number of lap entries; power of two, 2..16.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 sync_reset  input  1  reset, synchronous, active-high.
REQ-006 btn_start_stop  input  1  raw, asynchronous, bouncing button, active-high.
REQ-007 btn_lap  input  1  raw lap button, active-high.
REQ-008 btn_clear  input  1  raw clear button, active-high.
REQ-009 seconds_in  input  SECONDS_WIDTH  current seconds count from the stopwatch.
REQ-010 start  output  1  one-cycle pulse: stopwatch WAITING->COUNTING.
REQ-011 continue_pause  output  1  one-cycle pulse: stopwatch toggles COUNTING/PAUSED.
REQ-012 sw_reset_n  output  1  active-low reset driven to the stopwatch.
REQ-013 running  output  1  high while FSM in RUNNING.
REQ-014 lap_sel  input  log2(LAP_DEPTH)  lap entry read index.
REQ-015 lap_value  output  SECONDS_WIDTH  entry at lap_sel; 0 if lap_sel >= lap_count.
REQ-016 lap_count  output  log2(LAP_DEPTH)+1  number of stored laps.
REQ-017 lap_full  output  1  sticky: a lap press was dropped because the buffer was full.

Function
REQ-018 Each button SHALL pass a 2-flop synchronizer and then a debouncer; the counter restarts on any synchronized change and updates the debounced level after DEBOUNCE_CYCLES stable cycles.
REQ-019 A press event SHALL be a one-cycle pulse on the debounced rising edge; release SHALL generate no event.
REQ-020 start/continue_pause SHALL be registered; a clean press held stable SHALL produce the output pulse exactly DEBOUNCE_CYCLES+3 rising edges after the first edge sampling the raw input high.
REQ-021 FSM states SHALL be CLEARING, IDLE, RUNNING, PAUSED.
REQ-022 CLEARING: sw_reset_n=0 for exactly 2 cycles, lap buffer and lap_count and lap_full cleared, then IDLE; all press events during CLEARING dropped.
REQ-023 IDLE: start_stop press -> pulse start, go RUNNING; clear press -> CLEARING; lap press ignored.
REQ-024 RUNNING: start_stop press -> pulse continue_pause, go PAUSED; clear press ignored.
REQ-025 RUNNING: lap press with lap_count < LAP_DEPTH -> write seconds_in (sampled in the event cycle) to entry lap_count, increment lap_count; with lap_count == LAP_DEPTH -> no write, set lap_full.
REQ-026 Simultaneous lap and start_stop events in RUNNING SHALL both take effect: lap captured and pause issued in the same cycle.
REQ-027 PAUSED: start_stop press -> pulse continue_pause, go RUNNING; lap press ignored; clear press -> CLEARING.
REQ-028 Simultaneous clear and start_stop events in PAUSED or IDLE: clear SHALL win, no start/continue_pause pulse.
REQ-029 start and continue_pause SHALL never be high in the same cycle and SHALL never be high for two consecutive cycles.
REQ-030 lap_value SHALL be combinational from lap_sel and the buffer; lap_count SHALL saturate at LAP_DEPTH, never wrap.

Reset
REQ-031 While sync_reset is high: start=0, continue_pause=0, sw_reset_n=0, running=0, lap_count=0, lap_full=0, lap buffer all 0, synchronizers, debounced levels and debounce counters all 0.
REQ-032 On the first edge after sync_reset falls, the FSM SHALL be in CLEARING (REQ-022), then IDLE.
REQ-033 sync_reset mid-operation SHALL abort any state and pending debounce count immediately; a button held through reset SHALL produce exactly one press event after release of reset plus debounce.

Verification (DEBOUNCE_CYCLES=4, SECONDS_WIDTH=8, LAP_DEPTH=4)
REQ-034 Reset, then btn_start_stop high held -> sw_reset_n low 2 cycles after reset, start single pulse 7 edges after first high sample, running=1.
REQ-035 btn_start_stop toggling every 2 cycles for 20 cycles, then low -> no event, no pulses.
REQ-036 RUNNING, 5 lap presses with seconds_in 3,7,9,12,15 -> entries 3,7,9,12, lap_count=4, lap_full=1, lap_sel=3 gives 12.
REQ-037 RUNNING, lap and start_stop pressed together with seconds_in=42 -> entry 42 stored and one continue_pause pulse, state PAUSED.
REQ-038 PAUSED, clear and start_stop together -> no continue_pause, sw_reset_n low 2 cycles, lap_count=0, lap_full=0, IDLE.
REQ-039 RUNNING, btn_clear press -> ignored, laps retained, running stays 1.
